// File: rtl/dsp_result_checker.sv
// Purpose : golden-model response checker for the DSP48A1 operand/OPMODE -> P path.
// Latency : exp_p/mismatch/counters update LATENCY cycles after the valid_in sample.
// Backpres: none; observes the bus every cycle and never stalls stimulus or DUT.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   enable, clr           arm checker (low -> IDLE); sync clear of counters/flags/FAIL
//   valid_in              operand set below was issued to the DUT this cycle
//   a, b, d, c, carryin,
//   opmode                operands exactly as driven to the DUT
//   p_dut                 DUT P output
//   exp_p                 golden value at the compare slot (registered)
//   mismatch              one-cycle pulse on a compare failure
//   err_sticky            set by any mismatch until clr/reset
//   check_cnt, err_cnt,
//   skip_cnt              saturating counters: compares, mismatches, skipped entries
//   state                 00 IDLE, 01 WARMUP, 10 CHECK, 11 FAIL
// Optional feature macro: CHECKER_FIRST_FAIL_EN adds first_exp/first_got/first_idx,
// capturing the first mismatch after reset/clr.
module dsp_result_checker #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned MAX_ERR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clr,
    input  logic        valid_in,
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic [17:0] d,
    input  logic [47:0] c,
    input  logic        carryin,
    input  logic [7:0]  opmode,
    input  logic [47:0] p_dut,
    output logic [47:0] exp_p,
    output logic        mismatch,
    output logic        err_sticky,
    output logic [15:0] check_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] skip_cnt,
    output logic [1:0]  state
`ifdef CHECKER_FIRST_FAIL_EN
    ,
    output logic [47:0] first_exp,
    output logic [47:0] first_got,
    output logic [15:0] first_idx
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WARMUP = 2'b01,
        ST_CHECK  = 2'b10,
        ST_FAIL   = 2'b11
    } state_t;

    typedef struct packed {
        logic        vld;
        logic        skp;
        logic [47:0] exp;
    } ent_t;

    localparam logic [15:0] MAX_ERR_W  = 16'(MAX_ERR);
    localparam logic [3:0]  WARM_LAST  = 4'(LATENCY - 1);

    state_t      st_q, st_d;
    logic [3:0]  wcnt_q;
    ent_t        dl_q [LATENCY];
    ent_t        ent_in;
    ent_t        head;

    logic [17:0] b_pre;
    logic [35:0] mult;
    logic [47:0] x_mux, z_mux, cin48, gold;
    logic        unsup;

    logic        slot, do_chk, do_skip, miss;
    logic [15:0] check_cnt_nxt, err_cnt_nxt, skip_cnt_nxt;

    // OPMODE[5] (carry-in select) does not alter the modelled result.
    logic        unused_carryinsel;
    assign unused_carryinsel = opmode[5];

    // ---------------------------------------------------------------
    // Golden model of the supported datapath subset
    // ---------------------------------------------------------------
    always_comb begin
        b_pre = b;
        if (opmode[4]) begin
            b_pre = opmode[6] ? (d - b) : (d + b);
        end
        mult = {18'b0, a} * {18'b0, b_pre};

        case (opmode[1:0])
            2'b01:   x_mux = {12'b0, mult};
            2'b11:   x_mux = {d[11:0], a, b};
            default: x_mux = '0;
        endcase

        z_mux = (opmode[3:2] == 2'b11) ? c : '0;
        cin48 = {47'b0, carryin};
        gold  = opmode[7] ? (z_mux - (x_mux + cin48)) : (z_mux + x_mux + cin48);

        // X=10 and Z=01/10 select P/PCIN feedback, which this model cannot predict.
        unsup = (opmode[1:0] == 2'b10) || (opmode[3:2] == 2'b01) || (opmode[3:2] == 2'b10);
    end

    assign ent_in = {valid_in, unsup, gold};
    assign head   = dl_q[LATENCY-1];

    // ---------------------------------------------------------------
    // Delay line: shifts every cycle regardless of FSM state
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= ent_in;
            for (int i = 1; i < LATENCY; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // ---------------------------------------------------------------
    // Compare slot and saturating counter next values
    // ---------------------------------------------------------------
    assign slot    = (st_q == ST_CHECK) && head.vld;
    assign do_chk  = slot && !head.skp;
    assign do_skip = slot && head.skp;
    assign miss    = do_chk && (p_dut != head.exp);

    assign check_cnt_nxt = (do_chk  && check_cnt != 16'hFFFF) ? check_cnt + 16'd1 : check_cnt;
    assign err_cnt_nxt   = (miss    && err_cnt   != 16'hFFFF) ? err_cnt   + 16'd1 : err_cnt;
    assign skip_cnt_nxt  = (do_skip && skip_cnt  != 16'hFFFF) ? skip_cnt  + 16'd1 : skip_cnt;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (clr || !enable) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE:   st_d = ST_WARMUP;
                ST_WARMUP: if (wcnt_q == WARM_LAST) st_d = ST_CHECK;
                // Threshold compare (not equality) so a saturated count still holds FAIL.
                ST_CHECK:  if (err_cnt_nxt >= MAX_ERR_W) st_d = ST_FAIL;
                default:   st_d = st_q;
            endcase
        end
    end

    // Warm-up cycle counter; idles at zero outside WARMUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (st_q == ST_WARMUP) begin
            wcnt_q <= wcnt_q + 4'd1;
        end else begin
            wcnt_q <= '0;
        end
    end

    assign state = st_q;

    // ---------------------------------------------------------------
    // Result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_p <= '0;
        end else begin
            exp_p <= head.exp;
        end
    end

    // clr has priority over a same-cycle mismatch: nothing is counted or pulsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            check_cnt  <= '0;
            err_cnt    <= '0;
            skip_cnt   <= '0;
        end else if (clr) begin
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            check_cnt  <= '0;
            err_cnt    <= '0;
            skip_cnt   <= '0;
        end else begin
            mismatch  <= miss;
            check_cnt <= check_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            skip_cnt  <= skip_cnt_nxt;
            if (miss) begin
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef CHECKER_FIRST_FAIL_EN
    // err_sticky low means no mismatch yet since reset/clr; first_idx is the
    // check count including the failing compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_exp <= '0;
            first_got <= '0;
            first_idx <= '0;
        end else if (clr) begin
            first_exp <= '0;
            first_got <= '0;
            first_idx <= '0;
        end else if (miss && !err_sticky) begin
            first_exp <= head.exp;
            first_got <= p_dut;
            first_idx <= check_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_dsp_result_checker.sv
// Purpose : self-checking bench for dsp_result_checker against a queue-based reference.
// Latency : reference pipe of LATENCY entries; outputs sampled 1 ns after each rising edge.
// Backpres: none; the bench plays the DUT role and drives p_dut from the reference pipe.
module tb_dsp_result_checker;

    localparam int L    = 4;
    localparam int MAXE = 1;

    logic        clk = 1'b0;
    logic        rst_n, enable, clr, valid_in, carryin;
    logic [17:0] a, b, d;
    logic [47:0] c, p_dut;
    logic [7:0]  opmode;
    logic [47:0] exp_p;
    logic        mismatch, err_sticky;
    logic [15:0] check_cnt, err_cnt, skip_cnt;
    logic [1:0]  state;
`ifdef CHECKER_FIRST_FAIL_EN
    logic [47:0] first_exp, first_got;
    logic [15:0] first_idx;
`endif

    dsp_result_checker #(.LATENCY(L), .MAX_ERR(MAXE)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .valid_in(valid_in),
        .a(a), .b(b), .d(d), .c(c), .carryin(carryin), .opmode(opmode), .p_dut(p_dut),
        .exp_p(exp_p), .mismatch(mismatch), .err_sticky(err_sticky),
        .check_cnt(check_cnt), .err_cnt(err_cnt), .skip_cnt(skip_cnt), .state(state)
`ifdef CHECKER_FIRST_FAIL_EN
        , .first_exp(first_exp), .first_got(first_got), .first_idx(first_idx)
`endif
    );

    always #5 clk = ~clk;

    // One issued operand set: whether it counts, whether it is unpredictable,
    // its golden P, and the P our pretend DUT will present for it.
    typedef struct {
        bit          vld;
        bit          skp;
        logic [47:0] exp;
        logic [47:0] pd;
    } ent_t;

    ent_t pipe[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference state
    int   run;       // edges since leaving IDLE (capped at L+1)
    bit   failed;
    bit   m_sticky;
    int   m_chk, m_err, m_skp;

    // Stimulus controls
    bit          rst_req;
    bit          force_en;
    logic [47:0] force_pd;

    function automatic logic [47:0] gold(input logic [17:0] ai, input logic [17:0] bi,
                                         input logic [17:0] di, input logic [47:0] ci,
                                         input logic cin, input logic [7:0] op);
        longint unsigned bb, m, x, z, p, av, bv, dv;
        av = longint'(ai);
        bv = longint'(bi);
        dv = longint'(di);
        bb = bv;
        if (op[4]) bb = (op[6] ? dv - bv : dv + bv) % 64'd262144;
        m = av * bb;
        case (op[1:0])
            2'b01:   x = m;
            2'b11:   x = (dv % 64'd4096) * (64'd1 << 36) + av * 64'd262144 + bv;
            default: x = 0;
        endcase
        z = (op[3:2] == 2'b11) ? longint'(ci) : 64'd0;
        p = op[7] ? z - (x + longint'(cin)) : z + x + longint'(cin);
        p = p % (64'd1 << 48);
        return p[47:0];
    endfunction

    function automatic bit unsupported(input logic [7:0] op);
        return (op[1:0] == 2'b10) || (op[3:2] == 2'b01) || (op[3:2] == 2'b10);
    endfunction

    function automatic int mstate();
        if (failed)   return 3;
        if (run == 0) return 0;
        if (run <= L) return 1;
        return 2;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic flush_pipe();
        ent_t z;
        z.vld = 0; z.skp = 0; z.exp = '0; z.pd = '0;
        pipe.delete();
        for (int i = 0; i < L; i++) pipe.push_back(z);
    endtask

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic set_ops(input int ai, input int bi, input longint ci, input int di,
                           input logic [7:0] op, input bit cin);
        a = 18'(ai); b = 18'(bi); c = 48'(ci); d = 18'(di); opmode = op; carryin = cin;
    endtask

    // One clock: drive p_dut for the entry due at this edge, clock, update the
    // reference, compare every output. Called just after a falling edge.
    task automatic step();
        ent_t        head, ne;
        logic [63:0] junk;
        logic [47:0] e_exp;
        bit          e_mis;
        int          st_b;

        head   = pipe[0];
        ne.vld = valid_in;
        ne.skp = unsupported(opmode);
        ne.exp = gold(a, b, d, c, carryin, opmode);
        ne.pd  = force_en ? force_pd : ne.exp;
        junk   = {$urandom, $urandom};
        p_dut  = head.vld ? head.pd : junk[47:0];
        rst_n  = !rst_req;

        @(posedge clk);
        #1;
        cyc++;

        if (rst_req) begin
            flush_pipe();
            run = 0; failed = 0; m_sticky = 0; m_chk = 0; m_err = 0; m_skp = 0;
            e_exp = '0; e_mis = 0;
        end else begin
            st_b = mstate();
            pipe.push_back(ne);
            head  = pipe.pop_front();
            e_exp = head.exp;
            e_mis = 0;
            if (clr) begin
                m_chk = 0; m_err = 0; m_skp = 0; m_sticky = 0;
            end else if (st_b == 2 && head.vld) begin
                if (head.skp) begin
                    m_skp = sat(m_skp + 1);
                end else begin
                    m_chk = sat(m_chk + 1);
                    if (head.pd !== head.exp) begin
                        e_mis = 1; m_err = sat(m_err + 1); m_sticky = 1;
                    end
                end
            end
            if (clr || !enable) begin
                run = 0; failed = 0;
            end else if (st_b == 2) begin
                if (m_err >= MAXE) failed = 1;
            end else if (st_b != 3) begin
                run++;
            end
        end

        chk("state",      48'(state),      48'(mstate()));
        chk("exp_p",      exp_p,           e_exp);
        chk("mismatch",   48'(mismatch),   48'(e_mis));
        chk("err_sticky", 48'(err_sticky), 48'(m_sticky));
        chk("check_cnt",  48'(check_cnt),  48'(m_chk));
        chk("err_cnt",    48'(err_cnt),    48'(m_err));
        chk("skip_cnt",   48'(skip_cnt),   48'(m_skp));

        @(negedge clk);
    endtask

    initial begin
        logic [63:0] r64;
        logic [7:0]  op8;
        bit          found;

        rst_n = 1'b0; enable = 1'b1; clr = 1'b0; valid_in = 1'b0; p_dut = '0;
        set_ops(0, 0, 0, 0, 8'h00, 1'b0);
        force_en = 0; force_pd = '0; rst_req = 1;
        run = 0; failed = 0; m_sticky = 0; m_chk = 0; m_err = 0; m_skp = 0;
        flush_pipe();
        @(negedge clk);

        // Reset held three cycles: everything reads zero / IDLE.
        repeat (3) step();
        rst_req = 0;

        // Warm-up: IDLE -> WARMUP for L cycles -> CHECK.
        repeat (L + 2) step();
        chk("warm_state", 48'(state), 48'd2);

        // 5*(8+6)+9 = 79, three back-to-back issues.
        set_ops(5, 6, 9, 8, 8'h1D, 1'b0);
        valid_in = 1;
        repeat (3) step();
        valid_in = 0;
        repeat (L + 1) step();
        chk("cnt79", 48'(check_cnt), 48'd3);
        chk("err79", 48'(err_cnt),   48'd0);

        // 10*(8+7)+10 = 160, 110*(588+78)+160 = 73420.
        valid_in = 1;
        set_ops(10, 7, 10, 8, 8'h1D, 1'b0);
        step();
        set_ops(110, 78, 160, 588, 8'h1D, 1'b0);
        step();
        valid_in = 0;
        repeat (L + 1) step();
        chk("cnt_pair", 48'(check_cnt), 48'd5);
        chk("err_pair", 48'(err_cnt),   48'd0);

        // DUT reports 79 where 160 is due: one mismatch, FAIL with MAX_ERR=1.
        set_ops(10, 7, 10, 8, 8'h1D, 1'b0);
        valid_in = 1; force_en = 1; force_pd = 48'd79;
        step();
        valid_in = 0; force_en = 0;
        repeat (L + 1) step();
        chk("fail_state",  48'(state),      48'd3);
        chk("fail_errcnt", 48'(err_cnt),    48'd1);
        chk("fail_sticky", 48'(err_sticky), 48'd1);
`ifdef CHECKER_FIRST_FAIL_EN
        chk("first_exp", first_exp, 48'd160);
        chk("first_got", first_got, 48'd79);
`endif

        // clr leaves FAIL, then re-arm.
        clr = 1;
        step();
        clr = 0;
        chk("clr_state", 48'(state), 48'd0);
        repeat (L + 2) step();

        // OPMODE 0A selects P feedback: entries skipped, not compared.
        set_ops(3, 4, 5, 6, 8'h0A, 1'b0);
        valid_in = 1;
        repeat (4) step();
        valid_in = 0;
        repeat (L + 1) step();
        chk("skip4",    48'(skip_cnt),  48'd4);
        chk("skip_chk", 48'(check_cnt), 48'd0);

        // clr lands in the very cycle a bad result is compared.
        set_ops(10, 7, 10, 8, 8'h1D, 1'b0);
        valid_in = 1; force_en = 1; force_pd = 48'd79;
        step();
        valid_in = 0; force_en = 0;
        found = 0;
        for (int i = 0; i < 4 * L && !found; i++) begin
            if (pipe[0].vld) found = 1;
            else step();
        end
        chk("clr_slot_found", 48'(found), 48'd1);
        clr = 1;
        step();
        clr = 0;
        chk("clrmis_state", 48'(state),    48'd0);
        chk("clrmis_err",   48'(err_cnt),  48'd0);
        chk("clrmis_pulse", 48'(mismatch), 48'd0);
        repeat (L + 2) step();

        // Reset with entries in flight: none of them may be compared later.
        set_ops(110, 78, 160, 588, 8'h1D, 1'b0);
        valid_in = 1;
        repeat (3) step();
        valid_in = 0;
        rst_req = 1;
        step();
        rst_req = 0;
        repeat (2 * L + 2) step();
        chk("rst_flush", 48'(check_cnt), 48'd0);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            r64 = {$urandom, $urandom};
            op8 = 8'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                if (op8[1:0] == 2'b10) op8[1:0] = 2'b01;
                if (op8[3:2] == 2'b01 || op8[3:2] == 2'b10) op8[3:2] = 2'b11;
            end
            set_ops(int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                    longint'(r64[47:0]), int'($urandom_range(0, 262143)), op8,
                    1'($urandom_range(0, 1)));
            valid_in = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 99) >= 3);
            clr      = ($urandom_range(0, 99) < 2);
            rst_req  = ($urandom_range(0, 199) == 0);
            force_en = ($urandom_range(0, 49) == 0);
            force_pd = gold(a, b, d, c, carryin, opmode) ^ (48'd1 << $urandom_range(0, 47));
            step();
        end
        valid_in = 0; enable = 1; clr = 0; rst_req = 0; force_en = 0;
        repeat (L + 1) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
